// File: rtl/term_ctl.sv
// Terminal write controller: byte interpreter, cursor tracking, hardware scroll.
// Optional TERM_TAB_EN enables horizontal tab stops every TABW columns.
module term_ctl #(
  parameter int COLS = 80,
  parameter int ROWS = 25,
  parameter int TABW = 8
) (
  input  logic        pixclk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        wr,
  output logic [11:0] waddr,
  output logic [7:0]  wdata,
  output logic [4:0]  top_row,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row,
  output logic        busy,
  output logic        overflow
);

  localparam logic [12:0] CELLS    = 13'(COLS * ROWS);
  localparam logic [11:0] CELLS_M1 = 12'(COLS * ROWS - 1);
  localparam logic [11:0] CW       = 12'(COLS);
  localparam logic [11:0] CW_M1    = 12'(COLS - 1);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {
    INIT_CLR,
    IDLE,
    CLR_LINE,
    CLR_ALL
  } state_t;

  state_t      state;
  logic        hold_full;
  logic [7:0]  hold_data;
  logic [11:0] row_base;
  logic [11:0] clr_cnt;

  logic        take;
  logic        is_print;
  logic        lf;
  logic [6:0]  col_nxt;
  logic [12:0] rb_sum;
  logic [11:0] rb_inc;
  logic [4:0]  top_inc;
`ifdef TERM_TAB_EN
  logic [7:0]  tab;
`endif

  assign take = (state == IDLE) && hold_full;

  // row base of the next physical row, wrapping at the end of the buffer
  assign rb_sum  = {1'b0, row_base} + {1'b0, CW};
  assign rb_inc  = (rb_sum >= CELLS) ? 12'(rb_sum - CELLS) : rb_sum[11:0];
  assign top_inc = (top_row == LAST_ROW) ? 5'd0 : top_row + 5'd1;

  always_comb begin
    is_print = ((hold_data >= 8'h20) && (hold_data <= 8'h7E))
             || hold_data[7];
    col_nxt  = cur_col;
    lf       = 1'b0;
`ifdef TERM_TAB_EN
    tab      = 8'd0;
`endif
    unique case (1'b1)
      is_print: begin
        if (cur_col == LAST_COL) begin
          col_nxt = 7'd0;
          lf      = 1'b1;
        end else begin
          col_nxt = cur_col + 7'd1;
        end
      end
      (hold_data == 8'h0D): col_nxt = 7'd0;
      (hold_data == 8'h0A): lf = 1'b1;
      (hold_data == 8'h08): begin
        if (cur_col != 7'd0) col_nxt = cur_col - 7'd1;
      end
`ifdef TERM_TAB_EN
      (hold_data == 8'h09): begin
        tab = {1'b0, cur_col} - ({1'b0, cur_col} % 8'(TABW)) + 8'(TABW);
        if (tab >= 8'(COLS)) begin
          col_nxt = 7'd0;
          lf      = 1'b1;
        end else begin
          col_nxt = tab[6:0];
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
      overflow  <= 1'b0;
    end else if (rx_valid) begin
      if (hold_full && !take) begin
        overflow <= 1'b1;
      end else begin
        hold_full <= 1'b1;
        hold_data <= rx_data;
      end
    end else if (take) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT_CLR;
      wr       <= 1'b0;
      waddr    <= 12'd0;
      wdata    <= 8'h00;
      top_row  <= 5'd0;
      cur_col  <= 7'd0;
      cur_row  <= 5'd0;
      busy     <= 1'b0;
      row_base <= 12'd0;
      clr_cnt  <= 12'd0;
    end else begin
      wr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hold_full && hold_data == 8'h0C) begin
            state    <= CLR_ALL;
            busy     <= 1'b1;
            top_row  <= 5'd0;
            cur_col  <= 7'd0;
            cur_row  <= 5'd0;
            row_base <= 12'd0;
            clr_cnt  <= 12'd0;
          end else if (hold_full) begin
            if (is_print) begin
              wr    <= 1'b1;
              waddr <= row_base + 12'(cur_col);
              wdata <= hold_data;
            end
            cur_col <= col_nxt;
            if (lf) begin
              row_base <= rb_inc;
              if (cur_row < LAST_ROW) begin
                cur_row <= cur_row + 5'd1;
              end else begin
                // recycled row is the old top, whose base is rb_inc
                top_row <= top_inc;
                clr_cnt <= 12'd0;
                state   <= CLR_LINE;
                busy    <= 1'b1;
              end
            end
          end
        end
        CLR_LINE: begin
          wr      <= 1'b1;
          waddr   <= row_base + clr_cnt;
          wdata   <= 8'h20;
          clr_cnt <= clr_cnt + 12'd1;
          if (clr_cnt == CW_M1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            busy  <= 1'b1;
          end
        end
        default: begin
          wr      <= 1'b1;
          waddr   <= clr_cnt;
          wdata   <= 8'h20;
          clr_cnt <= clr_cnt + 12'd1;
          if (clr_cnt == CELLS_M1) begin
            state    <= IDLE;
            busy     <= 1'b0;
            top_row  <= 5'd0;
            cur_col  <= 7'd0;
            cur_row  <= 5'd0;
            row_base <= 12'd0;
          end else begin
            busy     <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_term_ctl.sv
// Directed testbench for term_ctl.
// Writes are logged from the wr port and compared against hand-computed values.
module tb_term_ctl;

  logic        pixclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        wr;
  logic [11:0] waddr;
  logic [7:0]  wdata;
  logic [4:0]  top_row;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  logic [11:0] wa_q[$];
  logic [7:0]  wd_q[$];

  term_ctl dut (
    .pixclk   (pixclk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .wr       (wr),
    .waddr    (waddr),
    .wdata    (wdata),
    .top_row  (top_row),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 pixclk = ~pixclk;

  always @(posedge pixclk) begin
    #1;
    if (rst_n && wr) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
    end
  end

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge pixclk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge pixclk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    repeat (3) @(negedge pixclk);
    while (busy && n < maxc) begin
      @(negedge pixclk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, want 0", busy, n);
    end
    repeat (2) @(negedge pixclk);
  endtask

  task automatic full_clear();
    send(8'h0C);
    wait_idle(2100);
    clear_log();
  endtask

  task automatic test_reset();
    int bad;
    repeat (3) @(negedge pixclk);
    checks++;
    if ({wr, waddr, wdata, top_row, cur_col, cur_row, busy, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%0b waddr=%0d wdata=%h top=%0d col=%0d row=%0d busy=%0b ovf=%0b, want all 0",
               wr, waddr, wdata, top_row, cur_col, cur_row, busy, overflow);
    end
    clear_log();
    rst_n = 1'b1;
    wait_idle(2100);
    checks++;
    if (wa_q.size() != 2000) begin
      errors++;
      $display("FAIL init_count: got %0d writes, want 2000", wa_q.size());
    end
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++)
      if (wa_q[i] !== 12'(i) || wd_q[i] !== 8'h20) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL init_pattern: got %0d bad writes, want 0", bad);
    end
    checks++;
    if ({busy, top_row, cur_col, cur_row, overflow} !== '0) begin
      errors++;
      $display("FAIL init_state: got busy=%0b top=%0d col=%0d row=%0d ovf=%0b, want all 0",
               busy, top_row, cur_col, cur_row, overflow);
    end
  endtask

  task automatic test_print();
    clear_log();
    @(negedge pixclk);
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    @(negedge pixclk);
    rx_valid = 1'b0;
    checks++;
    if (wr !== 1'b0) begin
      errors++;
      $display("FAIL print_early: got wr=%0b, want 0", wr);
    end
    @(negedge pixclk);
    checks++;
    if (wr !== 1'b1 || waddr !== 12'd0 || wdata !== 8'h41) begin
      errors++;
      $display("FAIL print_write: got wr=%0b waddr=%0d wdata=%h, want 1 0 41", wr, waddr, wdata);
    end
    @(negedge pixclk);
    checks++;
    if (wr !== 1'b0 || cur_col !== 7'd1 || waddr !== 12'd0 || wdata !== 8'h41) begin
      errors++;
      $display("FAIL print_after: got wr=%0b col=%0d waddr=%0d wdata=%h, want 0 1 0 41",
               wr, cur_col, waddr, wdata);
    end
  endtask

  task automatic test_wrap();
    full_clear();
    for (int i = 0; i < 80; i++) send(8'h78);
    wait_idle(200);
    checks++;
    if (wa_q.size() != 80 || wa_q[$] !== 12'd79 || wd_q[$] !== 8'h78) begin
      errors++;
      $display("FAIL wrap_writes: got n=%0d last=%0d data=%h, want 80 79 78",
               wa_q.size(), wa_q[$], wd_q[$]);
    end
    checks++;
    if (cur_col !== 7'd0 || cur_row !== 5'd1 || top_row !== 5'd0) begin
      errors++;
      $display("FAIL wrap_cursor: got col=%0d row=%0d top=%0d, want 0 1 0", cur_col, cur_row, top_row);
    end
  endtask

  task automatic test_scroll();
    int bad;
    full_clear();
    for (int i = 0; i < 24; i++) send(8'h0A);
    wait_idle(100);
    clear_log();
    send(8'h0A);
    wait_idle(200);
    checks++;
    if (top_row !== 5'd1 || cur_row !== 5'd24 || cur_col !== 7'd0) begin
      errors++;
      $display("FAIL scroll_state: got top=%0d row=%0d col=%0d, want 1 24 0", top_row, cur_row, cur_col);
    end
    bad = (wa_q.size() == 80) ? 0 : 1;
    for (int i = 0; i < wa_q.size(); i++)
      if (wa_q[i] !== 12'(i) || wd_q[i] !== 8'h20) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL scroll_clear: got n=%0d with %0d faults, want 80 blanks at 0..79", wa_q.size(), bad);
    end
    clear_log();
    send(8'h42);
    wait_idle(20);
    checks++;
    if (wa_q.size() != 1 || wa_q[0] !== 12'd0 || wd_q[0] !== 8'h42) begin
      errors++;
      $display("FAIL scroll_print: got n=%0d addr=%0d data=%h, want 1 0 42", wa_q.size(), wa_q[0], wd_q[0]);
    end
  endtask

  task automatic test_backspace();
    full_clear();
    send(8'h41);
    send(8'h42);
    send(8'h08);
    send(8'h43);
    wait_idle(20);
    checks++;
    if (wa_q.size() != 3 || wa_q[0] !== 12'd0 || wa_q[1] !== 12'd1 || wa_q[2] !== 12'd1 ||
        wd_q[0] !== 8'h41 || wd_q[1] !== 8'h42 || wd_q[2] !== 8'h43) begin
      errors++;
      $display("FAIL bs_writes: got n=%0d, want addr 0,1,1 data 41,42,43", wa_q.size());
    end
    checks++;
    if (cur_col !== 7'd2) begin
      errors++;
      $display("FAIL bs_col: got %0d, want 2", cur_col);
    end
    send(8'h0D);
    wait_idle(20);
    checks++;
    if (cur_col !== 7'd0) begin
      errors++;
      $display("FAIL cr_col: got %0d, want 0", cur_col);
    end
    clear_log();
    send(8'h08);
    send(8'h7F);
    wait_idle(20);
    checks++;
    if (cur_col !== 7'd0 || cur_row !== 5'd0 || wa_q.size() != 0) begin
      errors++;
      $display("FAIL bs_col0: got col=%0d row=%0d writes=%0d, want 0 0 0", cur_col, cur_row, wa_q.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    @(negedge pixclk);
    rx_valid = 1'b1;
    rx_data  = 8'h31;
    @(negedge pixclk);
    rx_data  = 8'h32;
    @(negedge pixclk);
    rx_valid = 1'b0;
    wait_idle(20);
    checks++;
    if (wa_q.size() != 2 || wa_q[0] !== 12'd0 || wa_q[1] !== 12'd1 ||
        wd_q[0] !== 8'h31 || wd_q[1] !== 8'h32 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b: got n=%0d ovf=%0b, want addr 0,1 data 31,32 ovf 0", wa_q.size(), overflow);
    end
  endtask

  task automatic test_overflow();
    clear_log();
    send(8'h0C);
    repeat (10) @(negedge pixclk);
    send(8'h41);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_first: got %0b, want 0", overflow);
    end
    repeat (10) @(negedge pixclk);
    send(8'h42);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_second: got %0b, want 1", overflow);
    end
    repeat (10) @(negedge pixclk);
    send(8'h43);
    wait_idle(2100);
    checks++;
    if (overflow !== 1'b1 || cur_col !== 7'd1 || wa_q.size() != 2001 ||
        wa_q[$] !== 12'd0 || wd_q[$] !== 8'h41) begin
      errors++;
      $display("FAIL ovf_after: got ovf=%0b col=%0d n=%0d last=%0d/%h, want 1 1 2001 0/41",
               overflow, cur_col, wa_q.size(), wa_q[$], wd_q[$]);
    end
  endtask

  task automatic test_tab();
    send(8'h78);
    send(8'h78);
    wait_idle(20);
    clear_log();
    send(8'h09);
    wait_idle(20);
    checks++;
`ifdef TERM_TAB_EN
    if (cur_col !== 7'd8 || wa_q.size() != 0) begin
      errors++;
      $display("FAIL tab: got col=%0d writes=%0d, want 8 0", cur_col, wa_q.size());
    end
`else
    if (cur_col !== 7'd3 || wa_q.size() != 0) begin
      errors++;
      $display("FAIL tab: got col=%0d writes=%0d, want 3 0", cur_col, wa_q.size());
    end
`endif
  endtask

  initial begin
    test_reset();
    test_print();
    test_wrap();
    test_scroll();
    test_backspace();
    test_back_to_back();
    test_overflow();
    test_tab();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/term_ctl.md
Name: term_ctl

Overview:
- Terminal write controller between the serial receiver and the video RAM write port.
- Interprets received bytes: printable glyphs, CR, LF, BS and FF.
- Tracks the cursor and wraps lines automatically.
- Scrolls in hardware by rotating a top-row offset and blank-filling the recycled row; the display adds this offset to its row before addressing video RAM.

Parameters:
COLS, 80, characters per row
ROWS, 25, rows per screen (COLS*ROWS must be at most 4096)
TABW, 8, tab stop spacing in columns (used only with TERM_TAB_EN)

Ports:
pixclk  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle strobe: rx_data valid
rx_data  in  8  received byte
wr  out  1  video RAM write enable, one cycle per character cell
waddr  out  12  video RAM write address, physical_row*COLS+col
wdata  out  8  video RAM write data
top_row  out  5  physical row currently displayed as logical row 0
cur_col  out  7  cursor column, 0..COLS-1
cur_row  out  5  cursor logical row, 0..ROWS-1
busy  out  1  high while in any state other than IDLE
overflow  out  1  sticky: a byte was dropped

Behaviour:
- Reset (async assert): all outputs 0, hold register empty, state INIT_CLR. Release of reset resumes from INIT_CLR.
- Reset mid-operation: any clear sequence is aborted and restarts from INIT_CLR.
- Hold register (1 entry):
  - rx_valid at edge N loads it.
  - If it is full and not being consumed at edge N, the byte is dropped and overflow sets.
  - Consume and load in the same edge is legal; no drop.
- Addressing:
  - Physical row = (top_row + cur_row) mod ROWS.
  - Row base is kept incrementally (add/subtract COLS, wrap at COLS*ROWS); no multiplier.
- State IDLE, hold full, decode at edge N+1. Printable means 0x20..0x7E and 0x80..0xFF.
  - Printable: wr=1, waddr=row base+cur_col, wdata=byte, all registered at edge N+1, so wr is high for the cycle after edge N+1. cur_col increments. If cur_col was COLS-1, cur_col becomes 0 and LF handling follows.
  - 0x0D CR: cur_col=0.
  - 0x0A LF: if cur_row<ROWS-1, cur_row+1. Else cur_row stays, top_row=(top_row+1) mod ROWS, go to CLR_LINE for the recycled physical row (old top_row).
  - 0x08 BS: if cur_col>0, cur_col-1; no erase. At col 0: no change.
  - 0x0C FF: go to CLR_ALL.
  - Other bytes, including 0x7F: consumed, ignored.
- CLR_LINE: COLS consecutive cycles with wr=1, wdata=0x20, waddr=recycled row base+0..COLS-1, then IDLE.
- CLR_ALL / INIT_CLR:
  - COLS*ROWS consecutive writes of 0x20 at addresses 0..COLS*ROWS-1, ascending.
  - Then top_row=0, cur_col=0, cur_row=0, IDLE.
  - CLR_ALL sets top_row, cur_col and cur_row to 0 on entry.
- wr is never high outside the printable-write cycle and the clear states. wdata and waddr hold their last value when wr=0.
- Byte acceptance continues in all states into the hold register. Bytes are processed only in IDLE.

Optional Feature:
- Macro TERM_TAB_EN defined: 0x09 sets cur_col to the next multiple of TABW strictly greater than cur_col. If the result is at least COLS, cur_col=0 and LF handling follows. No cells are written.
- Undefined: 0x09 is ignored like any other control byte.

Test Plan:
- Release rst_n -> COLS*ROWS=2000 wr pulses, addr 0..1999, wdata 0x20 -> then busy=0, top_row=0, cursor (0,0), overflow=0.
- After init, rx 0x41 -> single wr pulse waddr=0 wdata=0x41, rising at second edge after rx_valid; cur_col=1.
- 80 bytes 0x78 from (0,0) -> last write waddr=79; cursor becomes (col 0, row 1), no clear.
- Cursor on row 24, send 0x0A -> top_row=1; 80 writes of 0x20 at addr 0..79; cur_row=24. Then 0x42 -> wr waddr=0, wdata 0x42.
- Send 0x41,0x42,0x08,0x43 -> writes addr 0,1,1 (data 41,42,43), cur_col=2. Send 0x08 at col 0 -> no change.
- Send 0x0C, then 3 bytes spaced 10 cycles during the clear -> first held, second and third dropped, overflow=1 and sticky. With TERM_TAB_EN, 0x09 at col 3 -> cur_col=8.
